eq_coeff_ctrl: RTL



---
 rtl/eq_pkg.sv | 27 ++
 rtl/eq_coeff_ctrl_if.sv | 15 +
 rtl/eq_coeff_bank.sv | 76 +++++++
 rtl/eq_coeff_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer definitions: coefficient layout, FSM state encoding and clog2.
package eq_pkg;

    localparam int NR_EQ_BAND_COEFF = 5;

    // Word offset of each coefficient inside one band's group of five.
    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;

    typedef logic [1:0] eq_state_t;

    localparam eq_state_t ST_IDLE  = 2'd0;
    localparam eq_state_t ST_ARMED = 2'd1;
    localparam eq_state_t ST_DRAIN = 2'd2;
    localparam eq_state_t ST_SWAP  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/eq_coeff_ctrl_if.sv
// Valid/ready sample stream carrying a sample and its channel id.
interface eq_coeff_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ID_W   = 2
) ();

    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tid, output tvalid, input tready);
    modport slave  (input tdata, input tid, input tvalid, output tready);

endinterface

// File: rtl/eq_coeff_bank.sv
// Dual-bank coefficient RAM: host writes the shadow bank, equalizer reads the active bank.
// Optional shadow readback port when EQ_COEFF_READBACK_EN is defined.
module eq_coeff_bank
    import eq_pkg::*;
#(
    parameter int NR_EQ_COEFF    = 160,
    parameter int EQ_COEFF_WIDTH = 32,
    parameter int ADDR_W         = clog2(NR_EQ_COEFF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      active_bank_i,
    input  logic                      wr_en_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [EQ_COEFF_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    output logic [EQ_COEFF_WIDTH-1:0] rd_data_o
`ifdef EQ_COEFF_READBACK_EN
    ,
    input  logic                      rb_en_i,
    input  logic [ADDR_W-1:0]         rb_addr_i,
    output logic [EQ_COEFF_WIDTH-1:0] rb_data_o,
    output logic                      rb_vld_o
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NR_EQ_COEFF - 1);

    logic [EQ_COEFF_WIDTH-1:0] mem_q [0:1][0:NR_EQ_COEFF-1];
    logic [EQ_COEFF_WIDTH-1:0] rd_data_q;
    logic                      shadow_bank;

    assign shadow_bank = ~active_bank_i;

    // Memory contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i <= ADDR_LAST)) begin
            mem_q[shadow_bank][wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_addr_i <= ADDR_LAST) begin
            rd_data_q <= mem_q[active_bank_i][rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef EQ_COEFF_READBACK_EN
    logic [EQ_COEFF_WIDTH-1:0] rb_data_q;
    logic                      rb_vld_q;

    always_ff @(posedge clk) begin
        if (rb_en_i) begin
            rb_data_q <= (rb_addr_i <= ADDR_LAST) ? mem_q[shadow_bank][rb_addr_i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_vld_q <= 1'b0;
        end else begin
            rb_vld_q <= rb_en_i;
        end
    end

    assign rb_data_o = rb_data_q;
    assign rb_vld_o  = rb_vld_q;
`endif

endmodule

// File: rtl/eq_coeff_ctrl.sv
// Coefficient controller: shadow/active banks swapped at a frame boundary after draining the equalizer.
// Define EQ_COEFF_READBACK_EN to add the shadow-bank readback port.
module eq_coeff_ctrl
    import eq_pkg::*;
#(
    parameter int NR_CHANNELS    = 4,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32,
    parameter int INPUT_WIDTH    = 24,
    parameter int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
    parameter int ADDR_W         = clog2(NR_EQ_COEFF),
    parameter int CH_W           = clog2(NR_CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [EQ_COEFF_WIDTH-1:0] cfg_data,
    input  logic                      cfg_wr,
    output logic                      cfg_ready,
    input  logic                      cfg_commit,
    output logic                      cfg_pending,
    output logic                      cfg_done,
    output logic                      active_bank,

    eq_coeff_ctrl_if.slave            up,
    eq_coeff_ctrl_if.master           eq_s,

    input  logic                      eq_m_tvalid,
    input  logic                      eq_m_tready,

    input  logic [ADDR_W-1:0]         eq_coeff_addr,
    output logic [EQ_COEFF_WIDTH-1:0] eq_coeff
`ifdef EQ_COEFF_READBACK_EN
    ,
    input  logic                      cfg_rd,
    input  logic [ADDR_W-1:0]         cfg_raddr,
    output logic [EQ_COEFF_WIDTH-1:0] cfg_rdata,
    output logic                      cfg_rvalid
`endif
);

    eq_state_t  state_q, state_d;
    logic [1:0] inflight_q, inflight_d;
    logic       active_q, active_d;
    logic       hold;
    logic       s_fire, m_fire;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        hold     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) state_d = ST_ARMED;
            end
            // Stop only at the first sample of a frame so the current frame completes.
            ST_ARMED: begin
                hold = up.tvalid && (up.tid == '0);
                if (hold) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                hold = 1'b1;
                if (inflight_q == 2'd0) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                hold     = 1'b1;
                active_d = ~active_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s_fire     = eq_s.tvalid && eq_s.tready;
    assign m_fire     = eq_m_tvalid && eq_m_tready;
    assign inflight_d = inflight_q + 2'(s_fire) - 2'(m_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            active_q   <= 1'b0;
            inflight_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            inflight_q <= inflight_d;
        end
    end

    assign eq_s.tdata  = up.tdata;
    assign eq_s.tid    = up.tid;
    assign eq_s.tvalid = up.tvalid & ~hold;
    assign up.tready   = eq_s.tready & ~hold;

    assign cfg_ready   = (state_q == ST_IDLE);
    assign cfg_pending = (state_q != ST_IDLE);
    assign cfg_done    = (state_q == ST_SWAP);
    assign active_bank = active_q;

    eq_coeff_bank #(
        .NR_EQ_COEFF    (NR_EQ_COEFF),
        .EQ_COEFF_WIDTH (EQ_COEFF_WIDTH),
        .ADDR_W         (ADDR_W)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .active_bank_i (active_q),
        .wr_en_i       (cfg_wr && cfg_ready),
        .wr_addr_i     (cfg_addr),
        .wr_data_i     (cfg_data),
        .rd_addr_i     (eq_coeff_addr),
        .rd_data_o     (eq_coeff)
`ifdef EQ_COEFF_READBACK_EN
        ,
        .rb_en_i       (cfg_rd),
        .rb_addr_i     (cfg_raddr),
        .rb_data_o     (cfg_rdata),
        .rb_vld_o      (cfg_rvalid)
`endif
    );

endmodule
